// File: rtl/nios2_vjtag_host_master.sv
// -----------------------------------------------------------------------------
// nios2_vjtag_host_master
//
// Host-side initiator for the Nios II debug-module virtual-JTAG port. It takes
// one command at a time (IR value + scan word), walks the target through
// UIR -> CDR -> SDR -> UDR -> RTI with a generated tck, shifts the word out
// LSB-first on vji_tdi, collects vji_tdo into a response word and hands that
// word back to the requester.
//
// Each tck period is a low half followed by a high half, TCK_DIV clk cycles
// each. Strobes, tdi and ir_in change only on the clk edge that starts a low
// half. tdo is sampled on the last clk cycle of the low half, i.e. on the same
// clk edge that raises tck (the target shifts on that rising edge).
//
// Optional build macro: NIOS2_VJTAG_HOST_IR_CACHE_EN
//   When defined, the last loaded IR is remembered (valid flag cleared by
//   reset) and a command carrying the same IR skips the UIR period.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     command handshake (cmd_ready high only in IDLE)
//   cmd_ir, cmd_data        instruction and scan word, latched on handshake
//   rsp_valid/rsp_ready     response handshake, rsp_valid held until accepted
//   rsp_data                captured tdo bits, bit i = i-th shifted bit
//   vji_tck, vji_tdi        generated test clock and serial data out
//   vji_tdo                 serial data from target
//   vji_ir_in               instruction presented to target
//   vji_uir/cdr/sdr/udr/rti one-hot state strobes, all low in IDLE/RESP
// -----------------------------------------------------------------------------
module nios2_vjtag_host_master #(
    parameter int SR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 2,
    parameter int RTI_TCKS = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [SR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [SR_WIDTH-1:0] rsp_data,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);
    localparam int DIV_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam int CNT_W = $clog2(SR_WIDTH + RTI_TCKS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TCK_DIV - 1);
    localparam logic [CNT_W-1:0] SDR_LAST = CNT_W'(SR_WIDTH - 1);
    localparam logic [CNT_W-1:0] RTI_LAST = CNT_W'(RTI_TCKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UIR,
        S_CDR,
        S_SDR,
        S_UDR,
        S_RTI,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [DIV_W-1:0]    r_div;
    logic                r_phase;     // 0 = tck low half, 1 = tck high half
    logic [CNT_W-1:0]    r_cnt;       // tck periods spent in the current state
    logic [SR_WIDTH-1:0] r_tx;
    logic [SR_WIDTH-1:0] r_rx;
    logic                r_tdi;
    logic [IR_WIDTH-1:0] r_ir;

    logic w_active;
    logic w_half_end;
    logic w_period_end;
    logic w_sample;
    logic w_load;
    logic w_ir_hit;

    assign w_active     = (r_state != S_IDLE) && (r_state != S_RESP);
    assign w_half_end   = w_active && (r_div == DIV_LAST);
    assign w_period_end = w_half_end && r_phase;
    // Last clk of the low half: tck rises on this edge, so tdo is still the
    // bit the target presented for the current period.
    assign w_sample     = w_half_end && !r_phase;
    assign w_load       = (r_state == S_IDLE) && cmd_valid;

`ifdef NIOS2_VJTAG_HOST_IR_CACHE_EN
    // r_ir already holds the last IR loaded; only the valid flag is extra.
    logic r_ir_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ir_valid <= 1'b0;
        end else if (w_load) begin
            r_ir_valid <= 1'b1;
        end
    end

    assign w_ir_hit = r_ir_valid && (cmd_ir == r_ir);
`else
    assign w_ir_hit = 1'b0;
`endif

    // Next state and decoded outputs.
    always_comb begin
        w_state_next = r_state;
        cmd_ready    = 1'b0;
        rsp_valid    = 1'b0;
        vji_uir      = 1'b0;
        vji_cdr      = 1'b0;
        vji_sdr      = 1'b0;
        vji_udr      = 1'b0;
        vji_rti      = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_state_next = w_ir_hit ? S_CDR : S_UIR;
                end
            end
            S_UIR: begin
                vji_uir = 1'b1;
                if (w_period_end) w_state_next = S_CDR;
            end
            S_CDR: begin
                vji_cdr = 1'b1;
                if (w_period_end) w_state_next = S_SDR;
            end
            S_SDR: begin
                vji_sdr = 1'b1;
                if (w_period_end && (r_cnt == SDR_LAST)) w_state_next = S_UDR;
            end
            S_UDR: begin
                vji_udr = 1'b1;
                if (w_period_end) w_state_next = S_RTI;
            end
            S_RTI: begin
                vji_rti = 1'b1;
                if (w_period_end && (r_cnt == RTI_LAST)) w_state_next = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_phase <= 1'b0;
            r_cnt   <= '0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_tdi   <= 1'b0;
            r_ir    <= '0;
        end else begin
            r_state <= w_state_next;

            // tck divider; idles at the start of a low half outside the scan.
            if (!w_active || w_half_end) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
            if (!w_active) begin
                r_phase <= 1'b0;
            end else if (w_half_end) begin
                r_phase <= ~r_phase;
            end

            if (w_state_next != r_state) begin
                r_cnt <= '0;
            end else if (w_period_end) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            // tdi is presented at the start of each SDR period and forced low
            // at the start of any other period.
            if (w_load) begin
                r_tx <= cmd_data;
                r_ir <= cmd_ir;
            end else if (w_period_end) begin
                if (w_state_next == S_SDR) begin
                    r_tdi <= r_tx[0];
                    r_tx  <= r_tx >> 1;
                end else begin
                    r_tdi <= 1'b0;
                end
            end

            // Shift in from the top so the first captured bit lands in bit 0.
            if (w_load) begin
                r_rx <= '0;
            end else if ((r_state == S_SDR) && w_sample) begin
                r_rx <= {vji_tdo, r_rx[SR_WIDTH-1:1]};
            end
        end
    end

    assign vji_tck   = r_phase;
    assign vji_tdi   = r_tdi;
    assign vji_ir_in = r_ir;
    assign rsp_data  = r_rx;

endmodule
